// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - control/datapath bundle for the multicycle main control FSM
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       jr;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       bus_err;
  logic       illegal_op;

  // Controller side: consumes decode/status, drives strobes
  modport master (
    input  opcode, jr, zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, bus_err, illegal_op
  );

  // Datapath/memory side
  modport slave (
    output opcode, jr, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, bus_err, illegal_op
  );
endinterface

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM with memory wait watchdog
module multicycle_main_control #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int WAIT_W       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_main_control_if.master  bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] R_EXEC   = 4'd6;
  localparam logic [3:0] R_WB     = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] I_EXEC   = 4'd10;
  localparam logic [3:0] I_WB     = 4'd11;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // A zero limit turns the watchdog off; the compare value is then never used
  localparam bit               WD_EN     = (MEM_WAIT_MAX != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_state;
  logic              expire;

  // State and wait counter; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state, watchdog and all datapath strobes decoded from the current state
  always_comb begin
    state_d           = state_q;
    wait_d            = '0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.instr_done    = 1'b0;
    bus.bus_err       = 1'b0;
    bus.illegal_op    = 1'b0;

    mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    expire    = WD_EN && mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_R:             state_d = R_EXEC;
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_BEQ:           state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_ADDI, OP_ANDI: state_d = I_EXEC;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        if (bus.jr) begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b11;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else begin
          state_d = R_WB;
        end
      end
      R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        state_d           = FETCH;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (bus.opcode == OP_ANDI) ? 2'b11 : 2'b00;
        state_d       = I_WB;
      end
      I_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Expiry abandons the access: back to FETCH with no PC/IR/register/memory side effects
    if (expire) begin
      state_d       = FETCH;
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.bus_err   = 1'b1;
    end

    // Count only consecutive stalled cycles within one memory state
    if (mem_state && !expire && (state_d == state_q)) wait_d = wait_q + WAIT_W'(1);

    if (!rst_n) begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = 2'b00;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.instr_done    = 1'b0;
      bus.bus_err       = 1'b0;
      bus.illegal_op    = 1'b0;
    end
  end

endmodule
